// File: rtl/timer_pkg.sv
// Shared constants for the programmable timer:
// state encoding and oneshot/periodic mode values.
package timer_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prog.sv
// Programmable period timer with shadowed terminal count,
// periodic/oneshot modes, done pulse and sticky expired flag.
module timer_prog
    import timer_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            start,
    input  logic            stop,
    input  logic            oneshot,
    input  logic [BITS-1:0] final_value,
    output logic [BITS-1:0] Q,
    output logic            done,
    output logic            running,
    output logic            expired
);

    logic            r_state;
    logic [BITS-1:0] r_q;
    logic [BITS-1:0] r_shadow;
    logic            r_done;
    logic            r_expired;

    logic            w_state_nx;
    logic [BITS-1:0] w_q_nx;
    logic [BITS-1:0] w_shadow_nx;
    logic            w_done_nx;
    logic            w_expired_nx;

    logic            w_run;
    logic            w_advance;
    logic            w_terminal;
    logic [BITS-1:0] w_q_inc;

    assign w_run      = (r_state == ST_RUN);
    assign w_advance  = w_run && enable && !start && !stop;
    assign w_terminal = w_advance && (r_q == r_shadow);
    assign w_q_inc    = r_q + {{(BITS-1){1'b0}}, 1'b1};

    // Next-state selection; stop beats start, start beats counting.
    always_comb begin
        w_state_nx   = r_state;
        w_q_nx       = r_q;
        w_shadow_nx  = r_shadow;
        w_done_nx    = 1'b0;
        w_expired_nx = r_expired;
        if (stop) begin
            w_state_nx = ST_IDLE;
            w_q_nx     = '0;
        end else if (start) begin
            w_state_nx   = ST_RUN;
            w_q_nx       = '0;
            w_shadow_nx  = final_value;
            w_expired_nx = 1'b0;
        end else if (w_terminal) begin
            w_q_nx      = '0;
            w_done_nx   = 1'b1;
            w_shadow_nx = final_value;
            if (oneshot == MODE_ONESHOT) begin
                w_state_nx   = ST_IDLE;
                w_expired_nx = 1'b1;
            end
        end else if (w_advance) begin
            w_q_nx = w_q_inc;
        end else if (!w_run) begin
            w_q_nx = '0;
        end
    end

    // State, counter, shadow and flag registers with sync reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_q       <= '0;
            r_shadow  <= '0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_q       <= w_q_nx;
            r_shadow  <= w_shadow_nx;
            r_done    <= w_done_nx;
            r_expired <= w_expired_nx;
        end
    end

    assign Q       = r_q;
    assign done    = r_done;
    assign running = r_state;
    assign expired = r_expired;

endmodule

// File: tb/tb_timer_prog.sv
// Directed self-checking bench for timer_prog (BITS=4).
// Each task drives one scenario and checks outputs inline.
module tb_timer_prog;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic       stop;
    logic       oneshot;
    logic [3:0] final_value;
    logic [3:0] Q;
    logic       done;
    logic       running;
    logic       expired;

    int n_tests;
    int n_fail;

    timer_prog #(.BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .stop        (stop),
        .oneshot     (oneshot),
        .final_value (final_value),
        .Q           (Q),
        .done        (done),
        .running     (running),
        .expired     (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // outputs are observed 1ns after the edge they reflect
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // begin a period: one start edge, then release start
    task automatic do_start(input logic [3:0] fv, input logic os);
        final_value = fv;
        oneshot = os;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if ({running, done, expired, Q} !== 7'b0) begin
            $display("FAIL reset_state got r%b d%b e%b Q%0d want all 0",
                     running, done, expired, Q);
            n_fail++;
        end
        enable = 1'b1;
        tick();
        n_tests++;
        if ({running, Q} !== 5'b0) begin
            $display("FAIL reset_idle got r%b Q%0d want r0 Q0",
                     running, Q);
            n_fail++;
        end
    endtask

    task automatic test_periodic();
        logic [3:0] q_exp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        logic       d_exp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        enable = 1'b1;
        do_start(4'd3, 1'b0);
        n_tests++;
        if ({running, done, Q} !== {1'b1, 1'b0, 4'd0}) begin
            $display("FAIL periodic_start got r%b d%b Q%0d want r1 d0 Q0",
                     running, done, Q);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if ({running, done, Q} !== {1'b1, d_exp[i], q_exp[i]}) begin
                $display("FAIL periodic[%0d] got r%b d%b Q%0d want r1 d%b Q%0d",
                         i, running, done, Q, d_exp[i], q_exp[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [3:0] q_exp [16] = '{1, 1, 2, 2, 3, 3, 0, 0,
                                   1, 1, 2, 2, 3, 3, 0, 0};
        logic       d_exp [16] = '{0, 0, 0, 0, 0, 0, 1, 0,
                                   0, 0, 0, 0, 0, 0, 1, 0};
        enable = 1'b1;
        do_start(4'd3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            enable = (i % 2 == 0);
            tick();
            n_tests++;
            if ({done, Q} !== {d_exp[i], q_exp[i]}) begin
                $display("FAIL gating[%0d] got d%b Q%0d want d%b Q%0d",
                         i, done, Q, d_exp[i], q_exp[i]);
                n_fail++;
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_oneshot();
        logic [3:0] q_exp [5] = '{1, 2, 0, 0, 0};
        logic       d_exp [5] = '{0, 0, 1, 0, 0};
        logic       r_exp [5] = '{1, 1, 0, 0, 0};
        logic       e_exp [5] = '{0, 0, 1, 1, 1};
        enable = 1'b1;
        do_start(4'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({running, done, expired, Q} !==
                {r_exp[i], d_exp[i], e_exp[i], q_exp[i]}) begin
                $display("FAIL oneshot[%0d] got r%b d%b e%b Q%0d want r%b d%b e%b Q%0d",
                         i, running, done, expired, Q,
                         r_exp[i], d_exp[i], e_exp[i], q_exp[i]);
                n_fail++;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if (expired !== 1'b1) begin
            $display("FAIL oneshot_stop_keeps_expired got %b want 1", expired);
            n_fail++;
        end
        do_start(4'd2, 1'b1);
        n_tests++;
        if ({running, expired} !== 2'b10) begin
            $display("FAIL oneshot_restart got r%b e%b want r1 e0",
                     running, expired);
            n_fail++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_fv_zero();
        enable = 1'b1;
        do_start(4'd0, 1'b0);
        n_tests++;
        if (done !== 1'b0) begin
            $display("FAIL fv0_start got d%b want d0", done);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({running, done, Q} !== {1'b1, 1'b1, 4'd0}) begin
                $display("FAIL fv0[%0d] got r%b d%b Q%0d want r1 d1 Q0",
                         i, running, done, Q);
                n_fail++;
            end
        end
    endtask

    task automatic test_full_range();
        enable = 1'b1;
        do_start(4'd15, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_tests++;
            if ({done, Q} !== {1'b0, 4'(i)}) begin
                $display("FAIL full_range[%0d] got d%b Q%0d want d0 Q%0d",
                         i, done, Q, i);
                n_fail++;
            end
        end
        tick();
        n_tests++;
        if ({done, Q} !== {1'b1, 4'd0}) begin
            $display("FAIL full_range_wrap got d%b Q%0d want d1 Q0", done, Q);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({done, Q} !== {1'b0, 4'd1}) begin
            $display("FAIL full_range_after got d%b Q%0d want d0 Q1", done, Q);
            n_fail++;
        end
    endtask

    task automatic test_reload();
        logic [3:0] q_exp [9] = '{2, 3, 0, 1, 2, 3, 4, 5, 0};
        logic       d_exp [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        enable = 1'b1;
        do_start(4'd3, 1'b0);
        tick();
        n_tests++;
        if (Q !== 4'd1) begin
            $display("FAIL reload_pre got Q%0d want Q1", Q);
            n_fail++;
        end
        final_value = 4'd5;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_tests++;
            if ({done, Q} !== {d_exp[i], q_exp[i]}) begin
                $display("FAIL reload[%0d] got d%b Q%0d want d%b Q%0d",
                         i, done, Q, d_exp[i], q_exp[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_stop_priority();
        enable = 1'b1;
        do_start(4'd5, 1'b0);
        tick();
        tick();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        n_tests++;
        if ({running, done, Q} !== {1'b0, 1'b0, 4'd0}) begin
            $display("FAIL stop_start got r%b d%b Q%0d want r0 d0 Q0",
                     running, done, Q);
            n_fail++;
        end
        tick();
        tick();
        n_tests++;
        if ({running, Q} !== {1'b0, 4'd0}) begin
            $display("FAIL idle_ignores_enable got r%b Q%0d want r0 Q0",
                     running, Q);
            n_fail++;
        end
        do_start(4'd1, 1'b0);
        tick();
        n_tests++;
        if (Q !== 4'd1) begin
            $display("FAIL stop_term_pre got Q%0d want Q1", Q);
            n_fail++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if ({running, done, Q} !== {1'b0, 1'b0, 4'd0}) begin
            $display("FAIL stop_terminal got r%b d%b Q%0d want r0 d0 Q0",
                     running, done, Q);
            n_fail++;
        end
    endtask

    task automatic test_reset_midrun();
        enable = 1'b1;
        do_start(4'd1, 1'b1);
        tick();
        tick();
        n_tests++;
        if (expired !== 1'b1) begin
            $display("FAIL rst_pre_expired got e%b want e1", expired);
            n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (expired !== 1'b0) begin
            $display("FAIL rst_clears_expired got e%b want e0", expired);
            n_fail++;
        end
        do_start(4'd7, 1'b0);
        tick();
        tick();
        n_tests++;
        if (Q !== 4'd2) begin
            $display("FAIL rst_midrun_pre got Q%0d want Q2", Q);
            n_fail++;
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        n_tests++;
        if ({running, done, expired, Q} !== 7'b0) begin
            $display("FAIL rst_midrun got r%b d%b e%b Q%0d want all 0",
                     running, done, expired, Q);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({running, Q} !== 5'b0) begin
                $display("FAIL rst_stay_idle[%0d] got r%b Q%0d want r0 Q0",
                         i, running, Q);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b0;
        enable = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        oneshot = 1'b0;
        final_value = 4'd0;
        test_reset();
        test_periodic();
        test_enable_gating();
        test_oneshot();
        test_fv_zero();
        test_full_range();
        test_reload();
        test_stop_priority();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
